// File: rtl/calc_pkg.sv
// Shared opcodes, widths and seven-segment constants for the calculator display block.
package calc_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned SEG_W  = 7;

    localparam logic [OP_W-1:0] OP_ADD   = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB   = 4'h1;
    localparam logic [OP_W-1:0] OP_AND   = 4'h2;
    localparam logic [OP_W-1:0] OP_OR    = 4'h3;
    localparam logic [OP_W-1:0] OP_XOR   = 4'h4;
    localparam logic [OP_W-1:0] OP_NOT   = 4'h5;
    localparam logic [OP_W-1:0] OP_LT    = 4'h6;
    localparam logic [OP_W-1:0] OP_SHL   = 4'h7;
    localparam logic [OP_W-1:0] OP_SHR   = 4'h8;
    localparam logic [OP_W-1:0] OP_PASS1 = 4'h9;
    localparam logic [OP_W-1:0] OP_PASS2 = 4'hA;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} for hex digits 0..F
    localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decoder
    import calc_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [SEG_W-1:0] seg_c
);

    assign seg_c = HEX_SEG[nibble];

endmodule

// File: rtl/calc_result_display.sv
// Registered 16-bit ALU with multiplexed 4-digit result and 8-digit operand hex displays.
// Optional macro CARRY_DP_EN lights the result-display digit-0 decimal point on carry/borrow.
module calc_result_display
    import calc_pkg::*;
#(
    parameter int unsigned CNT_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   switch,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic [DATA_W-1:0] result,
    output logic [11:0]       anode,
    output logic [15:0]       segment
);

    localparam int unsigned RES_DIGITS = 4;
    localparam int unsigned OPD_DIGITS = 8;
    localparam int unsigned RES_SEL_W  = 2;
    localparam int unsigned OPD_SEL_W  = 3;

    logic [CNT_W-1:0]     cnt;
    logic [DATA_W-1:0]    sum_c;
    logic [DATA_W-1:0]    alu_c;
    logic [RES_SEL_W-1:0] d4;
    logic [OPD_SEL_W-1:0] d8;
    logic [2*DATA_W-1:0]  opd_word;
    logic [NIB_W-1:0]     res_nib;
    logic [NIB_W-1:0]     opd_nib;
    logic [SEG_W-1:0]     res_seg;
    logic [SEG_W-1:0]     opd_seg;
    logic                 res_dp_n;

    assign sum_c = op1 + op2;

    always_comb begin
        alu_c = '0;
        case (switch)
            OP_ADD:   alu_c = sum_c;
            OP_SUB:   alu_c = op1 - op2;
            OP_AND:   alu_c = op1 & op2;
            OP_OR:    alu_c = op1 | op2;
            OP_XOR:   alu_c = op1 ^ op2;
            OP_NOT:   alu_c = ~op1;
            OP_LT:    alu_c = (op1 < op2) ? DATA_W'(1) : '0;
            OP_SHL:   alu_c = op1 << op2[NIB_W-1:0];
            OP_SHR:   alu_c = op1 >> op2[NIB_W-1:0];
            OP_PASS1: alu_c = op1;
            OP_PASS2: alu_c = op2;
            default:  alu_c = '0;
        endcase
    end

    // Top counter bits pick the active digit; the two displays scan at different rates
    assign d4       = cnt[CNT_W-1 -: RES_SEL_W];
    assign d8       = cnt[CNT_W-1 -: OPD_SEL_W];
    assign opd_word = {op2, op1};
    assign res_nib  = result[{d4, 2'b00} +: NIB_W];
    assign opd_nib  = opd_word[{d8, 2'b00} +: NIB_W];

    seg7_hex_decoder u_res_dec (
        .nibble (res_nib),
        .seg_c  (res_seg)
    );

    seg7_hex_decoder u_opd_dec (
        .nibble (opd_nib),
        .seg_c  (opd_seg)
    );

`ifdef CARRY_DP_EN
    logic carry_c;
    logic carry_q;

    // Unsigned carry-out shows up as a wrapped sum smaller than either addend
    always_comb begin
        carry_c = 1'b0;
        case (switch)
            OP_ADD:  carry_c = (sum_c < op1);
            OP_SUB:  carry_c = (op1 < op2);
            default: carry_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_c;
        end
    end

    assign res_dp_n = ~(carry_q && (d4 == '0));
`else
    assign res_dp_n = 1'b1;
`endif

    // Counter, result and display drivers share one register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            result  <= '0;
            anode   <= '1;
            segment <= {SEG_BLANK, SEG_BLANK};
        end else begin
            cnt     <= cnt + CNT_W'(1);
            result  <= alu_c;
            anode   <= {~(OPD_DIGITS'(1) << d8), ~(RES_DIGITS'(1) << d4)};
            segment <= {1'b1, opd_seg, res_dp_n, res_seg};
        end
    end

endmodule

// File: tb/tb_calc_result_display.sv
// Scoreboard bench for calc_result_display: stimulus queues expectations, a negedge monitor checks them.
module tb_calc_result_display;

    localparam int unsigned CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  switch;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [15:0] result;
    logic [11:0] anode;
    logic [15:0] segment;

    calc_result_display #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .switch  (switch),
        .op1     (op1),
        .op2     (op2),
        .result  (result),
        .anode   (anode),
        .segment (segment)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the displays show counter value e-1
    int unsigned e;
    always @(posedge clk or posedge rst) begin
        if (rst) e <= 0;
        else     e <= e + 1;
    end

    typedef struct {
        string       name;
        int unsigned cyc;
        int          sel;
        logic [15:0] exp;
    } item_t;

    localparam int SEL_RES  = 0;
    localparam int SEL_AN   = 1;
    localparam int SEL_SLO  = 2;
    localparam int SEL_SHI  = 3;
    localparam int SEL_SEG  = 4;

    item_t q[$];
    int    passed = 0;
    int    total  = 0;

    logic [3:0] res_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] opd_an [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    task automatic expect_at(input string name, input int unsigned cyc, input int sel,
                             input logic [15:0] exp);
        item_t it;
        it.name = name;
        it.cyc  = cyc;
        it.sel  = sel;
        it.exp  = exp;
        q.push_back(it);
    endtask

    function automatic logic [15:0] actual(input int sel);
        case (sel)
            SEL_RES: return result;
            SEL_AN:  return {4'h0, anode};
            SEL_SLO: return {8'h00, segment[7:0]};
            SEL_SHI: return {8'h00, segment[15:8]};
            default: return segment;
        endcase
    endfunction

    // Monitor: pop every expectation whose sample cycle has arrived
    always @(negedge clk) begin
        item_t it;
        while (q.size() > 0 && q[0].cyc <= e) begin
            it = q.pop_front();
            total++;
            if (it.cyc < e)
                $display("FAIL %s: sample cycle %0d missed (now %0d)", it.name, it.cyc, e);
            else if (actual(it.sel) !== it.exp)
                $display("FAIL %s: got %h, expected %h", it.name, actual(it.sel), it.exp);
            else
                passed++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned dc();
        return (e - 1) & 15;
    endfunction

    task automatic run_op(input string name, input logic [3:0] sw, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp);
        switch = sw;
        op1    = a;
        op2    = b;
        expect_at(name, e + 1, SEL_RES, exp);
        step();
    endtask

    // Advance until result-display digit d is showing a settled result
    task automatic wait_res_digit(input int unsigned d);
        int n = 0;
        step();
        while (((dc() >> 2) & 3) != d && n < 20) begin
            step();
            n++;
        end
    endtask

    initial begin
        rst    = 1'b1;
        switch = 4'h0;
        op1    = 16'h0000;
        op2    = 16'h0000;
        #1;
        expect_at("rst_result", 0, SEL_RES, 16'h0000);
        expect_at("rst_anode",  0, SEL_AN,  16'h0FFF);
        expect_at("rst_segment", 0, SEL_SEG, 16'hFFFF);
        repeat (3) step();
        rst = 1'b0;
        step();
        expect_at("first_edge_anode", e, SEL_AN, 16'h0FEE);

        run_op("add", 4'h0, 16'h3333, 16'h2222, 16'h5555);
        wait_res_digit(0);
        expect_at("add_digit0", e, SEL_SLO, 16'h0092);

        run_op("sub_wrap", 4'h1, 16'h2222, 16'h3333, 16'hEEEF);
        wait_res_digit(0);
`ifdef CARRY_DP_EN
        expect_at("sub_digit0", e, SEL_SLO, 16'h000E);
`else
        expect_at("sub_digit0", e, SEL_SLO, 16'h008E);
`endif
        wait_res_digit(1);
        expect_at("sub_digit1", e, SEL_SLO, 16'h0086);

        run_op("and",   4'h2, 16'h3333, 16'h2222, 16'h2222);
        run_op("or",    4'h3, 16'h3333, 16'h2222, 16'h3333);
        run_op("xor",   4'h4, 16'h3333, 16'h2222, 16'h1111);
        run_op("not",   4'h5, 16'h3333, 16'h2222, 16'hCCCC);
        run_op("lt_f",  4'h6, 16'h3333, 16'h2222, 16'h0000);
        run_op("lt_t",  4'h6, 16'h2222, 16'h3333, 16'h0001);
        run_op("shl",   4'h7, 16'h3333, 16'h0004, 16'h3330);
        run_op("shr",   4'h8, 16'h3333, 16'h0004, 16'h0333);
        run_op("pass1", 4'h9, 16'h3333, 16'h2222, 16'h3333);
        run_op("pass2", 4'hA, 16'h3333, 16'h2222, 16'h2222);
        run_op("op_b",  4'hB, 16'h3333, 16'h2222, 16'h0000);
        run_op("op_f",  4'hF, 16'h3333, 16'h2222, 16'h0000);

        run_op("ovf_add", 4'h0, 16'hFFFF, 16'h0001, 16'h0000);
        for (int unsigned d = 0; d < 4; d++) begin
            wait_res_digit(d);
`ifdef CARRY_DP_EN
            expect_at("ovf_digit", e, SEL_SLO, (d == 0) ? 16'h0040 : 16'h00C0);
`else
            expect_at("ovf_digit", e, SEL_SLO, 16'h00C0);
`endif
        end

        switch = 4'h0;
        op1    = 16'h3333;
        op2    = 16'h2222;
        repeat (2) step();
        for (int i = 0; i < 32; i++) begin
            int unsigned c;
            step();
            c = dc();
            expect_at("scan_anode", e, SEL_AN, {4'h0, opd_an[c >> 1], res_an[c >> 2]});
            expect_at("scan_opd_seg", e, SEL_SHI, ((c >> 1) < 4) ? 16'h00B0 : 16'h00A4);
            expect_at("scan_res_seg", e, SEL_SLO, 16'h0092);
        end

        step();
        rst = 1'b1;
        #1;
        expect_at("mid_rst_result",  0, SEL_RES, 16'h0000);
        expect_at("mid_rst_anode",   0, SEL_AN,  16'h0FFF);
        expect_at("mid_rst_segment", 0, SEL_SEG, 16'hFFFF);
        repeat (2) step();
        rst = 1'b0;
        step();
        expect_at("rel_anode",   e, SEL_AN,  16'h0FEE);
        expect_at("rel_opd_seg", e, SEL_SHI, 16'h00B0);
        expect_at("rel_res_seg", e, SEL_SLO, 16'h00C0);
        expect_at("rel_result",  e, SEL_RES, 16'h5555);

        for (int n = 0; n < 20 && q.size() > 0; n++) step();
        step();
        if (q.size() > 0) begin
            $display("FAIL drain: %0d expectations never sampled", q.size());
            total += q.size();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
